// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size codes,
// FSM states and the access-legality rule.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Misaligned halves/words, the unused size code, or a simultaneous read+write.
  function automatic logic access_illegal(input logic rd, input logic wr,
                                          input logic [1:0] size, input logic [1:0] a);
    return (rd & wr) | (size == 2'b10) | ((size == SZ_HALF) & a[0]) |
           ((size == SZ_WORD) & (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_data_align.sv
// Byte-lane steering: store byte-enable/data replication and load lane
// extraction with sign or zero extension. Purely combinational.
module mem_access_unit_data_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = st_data_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_be_o    = 4'b0001 << st_addr_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      SZ_WORD: st_be_o = 4'b1111;
      default: st_be_o = 4'b0000;
    endcase
  end

  assign ld_byte = ld_rdata_i[{ld_addr_i, 3'b000} +: 8];
  assign ld_half = ld_rdata_i[{ld_addr_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack transaction per instruction,
// lane steering, load extension, timeout, and pipeline stall generation.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  input  logic         i_mem_read,
  input  logic         i_mem_write,
  input  logic [1:0]   i_size,
  input  logic         i_unsigned,
  input  logic [N-1:0] i_alu_result,
  input  logic [N-1:0] i_write_data,
  output logic         o_stall,
  output logic [N-1:0] o_load_data,
  output logic         o_load_valid,
  output logic         o_mem_err,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [N-1:0] o_mem_addr,
  output logic [N-1:0] o_mem_wdata,
  output logic [3:0]   o_mem_be,
  input  logic         i_mem_ack,
  input  logic [N-1:0] i_mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     size_q, addr_lo_q;
  logic           uns_q, mem_req_q, mem_we_q, load_valid_q, mem_err_q;
  logic [N-1:0]   mem_addr_q, mem_wdata_q, load_data_q;
  logic [3:0]     mem_be_q;

  logic           start, illegal, timeout_hit;
  logic [3:0]     st_be;
  logic [N-1:0]   st_wdata, ld_data;

  assign start       = i_valid & (i_mem_read | i_mem_write);
  assign illegal     = access_illegal(i_mem_read, i_mem_write, i_size, i_alu_result[1:0]);
  // TIMEOUT of 0 disables the limit; the counter then just free-runs.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign o_stall     = ((state_q == ST_IDLE) & start & ~illegal) | (state_q == ST_REQ);

  mem_access_unit_data_align u_align (
    .st_size_i     (i_size),
    .st_addr_i     (i_alu_result[1:0]),
    .st_data_i     (i_write_data),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .ld_size_i     (size_q),
    .ld_addr_i     (addr_lo_q),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (i_mem_rdata),
    .ld_data_o     (ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      size_q       <= 2'b00;
      addr_lo_q    <= 2'b00;
      uns_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= 4'b0000;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      mem_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && illegal) begin
            mem_err_q <= 1'b1;
          end else if (start) begin
            state_q     <= ST_REQ;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_mem_write;
            mem_addr_q  <= {i_alu_result[N-1:2], 2'b00};
            addr_lo_q   <= i_alu_result[1:0];
            size_q      <= i_size;
            uns_q       <= i_unsigned;
            mem_be_q    <= st_be;
            mem_wdata_q <= st_wdata;
          end
        end
        ST_REQ: begin
          if (i_mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_DONE;
            if (!mem_we_q) begin
              load_data_q  <= ld_data;
              load_valid_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            mem_err_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // The same instruction is still in the slot here, so it is not re-sampled.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_be     = mem_be_q;
  assign o_load_data  = load_data_q;
  assign o_load_valid = load_valid_q;
  assign o_mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against an arithmetic reference model
// of lane steering, extension, handshake timing and timeout.
module tb_mem_access_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, rd, wr, uns, ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        stall, load_valid, mem_err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_load = 32'h0;
  int txn_no = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.N(32), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_mem_read(rd), .i_mem_write(wr),
    .i_size(size), .i_unsigned(uns), .i_alu_result(addr), .i_write_data(wdata),
    .o_stall(stall), .o_load_data(load_data), .o_load_valid(load_valid),
    .o_mem_err(mem_err), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .i_mem_ack(ack), .i_mem_rdata(rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: sizes 0=byte, 1=half, 3=word, 2=invalid.
  function automatic bit m_illegal(bit r, bit w, int sz, int unsigned a);
    if (r && w) return 1;
    if (sz == 2) return 1;
    if (sz == 1 && (a % 2) != 0) return 1;
    if (sz == 3 && (a % 4) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(int sz, int unsigned a);
    if (sz == 0) return 4'(1 << (a % 4));
    if (sz == 1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(int sz, logic [31:0] d);
    if (sz == 0) return (d % 256) * 32'h0101_0101;
    if (sz == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(int sz, bit u, int unsigned a, logic [31:0] rw);
    int unsigned v;
    if (sz == 0) begin
      v = (rw >> (8 * (a % 4))) % 256;
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 1) begin
      v = (rw >> (16 * ((a % 4) / 2))) % 65536;
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return rw;
  endfunction

  // One instruction through the unit. ack_k: ack on the k-th cycle req is high; 0 = never.
  task automatic do_txn(input bit t_rd, input bit t_wr, input int t_sz, input bit t_uns,
                        input logic [31:0] t_addr, input logic [31:0] t_d,
                        input logic [31:0] t_rdata, input int ack_k);
    bit ill, acked, got_done;
    int stall_cnt, req_cnt, exp_req;
    txn_no++;
    $display("txn %0d: rd=%0b wr=%0b size=%0d uns=%0b addr=0x%08h data=0x%08h ack_k=%0d",
             txn_no, t_rd, t_wr, t_sz, t_uns, t_addr, t_d, ack_k);
    @(posedge clk); #1;
    valid = 1'b1; rd = t_rd; wr = t_wr; size = 2'(t_sz); uns = t_uns;
    addr = t_addr; wdata = t_d; ack = 1'b0;
    #1;
    if (!t_rd && !t_wr) begin
      check_eq("nostart_stall", stall, 0);
      @(posedge clk); #1;
      check_eq("nostart_req", mem_req, 0);
      check_eq("nostart_err", mem_err, 0);
      valid = 1'b0;
      return;
    end
    ill = m_illegal(t_rd, t_wr, t_sz, t_addr);
    if (ill) begin
      check_eq("ill_stall", stall, 0);
      @(posedge clk); #1;
      check_eq("ill_err", mem_err, 1);
      check_eq("ill_req", mem_req, 0);
      valid = 1'b0;
      @(posedge clk); #1;
      check_eq("ill_err_pulse", mem_err, 0);
      check_eq("ill_req2", mem_req, 0);
      return;
    end
    acked = (ack_k != 0) && (ack_k <= TO);
    exp_req = acked ? ack_k : TO;
    got_done = 0; stall_cnt = 0; req_cnt = 0;
    for (int c = 0; c < TO + 6 && !got_done; c++) begin
      if (stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check_eq("req_addr", mem_addr, t_addr & 32'hFFFF_FFFC);
          check_eq("req_we", mem_we, t_wr);
          if (t_wr) begin
            check_eq("req_be", mem_be, m_be(t_sz, t_addr));
            check_eq("req_wdata", mem_wdata, m_wdata(t_sz, t_d));
          end
        end
        if (ack_k != 0 && req_cnt == ack_k) begin
          ack = 1'b1; rdata = t_rdata;
        end else begin
          rdata = $urandom;
        end
      end
      @(posedge clk); #1;
      ack = 1'b0;
      if (req_cnt > 0 && !mem_req) got_done = 1;
    end
    check_eq("done_reached", 32'(got_done), 1);
    check_eq("req_cycles", req_cnt, exp_req);
    check_eq("stall_cycles", stall_cnt, exp_req + 1);
    check_eq("done_stall", stall, 0);
    check_eq("done_err", mem_err, acked ? 0 : 1);
    check_eq("done_lvalid", load_valid, (acked && t_rd) ? 1 : 0);
    if (acked && t_rd) last_load = m_load(t_sz, t_uns, t_addr, t_rdata);
    check_eq("load_data", load_data, last_load);
    @(posedge clk); #1;
    check_eq("idle_req", mem_req, 0);
    check_eq("idle_lvalid", load_valid, 0);
    check_eq("idle_err", mem_err, 0);
    valid = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int r, sz, k;
    logic [31:0] a;
    rst = 1'b1; valid = 1'b0; rd = 1'b0; wr = 1'b0; uns = 1'b0; ack = 1'b0;
    size = 2'b00; addr = '0; wdata = '0; rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_be", mem_be, 0);
    check_eq("rst_ldata", load_data, 0);
    check_eq("rst_lvalid", load_valid, 0);
    check_eq("rst_err", mem_err, 0);
    check_eq("rst_stall", stall, 0);
    rst = 1'b0;

    do_txn(0, 1, 0, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1);
    do_txn(1, 0, 0, 0, 32'h0000_2001, 32'h0, 32'h1234_8056, 1);
    check_eq("lb_value", load_data, 32'hFFFF_FF80);
    do_txn(1, 0, 0, 1, 32'h0000_2001, 32'h0, 32'h1234_8056, 2);
    check_eq("lbu_value", load_data, 32'h0000_0080);
    do_txn(1, 0, 1, 0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 1);
    check_eq("lh_value", load_data, 32'hFFFF_8001);
    do_txn(1, 0, 1, 0, 32'h0000_2001, 32'h0, 32'h0, 1);
    do_txn(1, 0, 3, 0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 5);
    check_eq("lw_value", load_data, 32'hCAFE_F00D);
    do_txn(1, 0, 3, 0, 32'h0000_3004, 32'h0, 32'h0, 0);
    check_eq("timeout_keeps_data", load_data, 32'hCAFE_F00D);
    do_txn(0, 0, 3, 0, 32'h0000_3008, 32'h0, 32'h0, 1);
    do_txn(1, 1, 3, 0, 32'h0000_3008, 32'h0, 32'h0, 1);
    do_txn(1, 0, 2, 0, 32'h0000_3008, 32'h0, 32'h0, 1);

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      sz = $urandom_range(0, 3);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = (sz == 3) ? (a & 32'hFFFF_FFFC) :
                                         (sz == 1) ? (a & 32'hFFFF_FFFE) : a;
      k  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      do_txn(r <= 4 || r == 9, r >= 5, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, k);
    end

    // Reset during REQ: request drops at once and a late ack is ignored.
    $display("txn %0d: reset during outstanding load", txn_no + 1);
    @(posedge clk); #1;
    valid = 1'b1; rd = 1'b1; wr = 1'b0; size = 2'b11; uns = 1'b0; addr = 32'h0000_4000;
    @(posedge clk); #1;
    check_eq("mid_req_high", mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_req", mem_req, 0);
    check_eq("mid_rst_stall", stall, 0);
    rst = 1'b0; ack = 1'b1; rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    ack = 1'b0;
    check_eq("late_ack_lvalid", load_valid, 0);
    check_eq("late_ack_req", mem_req, 0);
    check_eq("late_ack_stall", stall, 0);
    check_eq("late_ack_ldata", load_data, 0);
    @(posedge clk); #1;
    check_eq("late_ack_lvalid2", load_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
